// File: rtl/apb_master_bridge.sv
// Valid/ready command port to APB3 master bridge, one transfer in flight.
// Optional ACCESS-phase timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int unsigned     CNT_W     = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q     <= IDLE;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               pwrite_d = cmd_write;
               paddr_d  = cmd_addr;
               pwdata_d = cmd_wdata;
               state_d  = SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
               cnt_d    = '0;
`endif
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            // Completion is checked first so PREADY on the limit edge still wins.
            if (PREADY) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = PSLVERR;
               rsp_rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
`ifdef APB_MASTER_TIMEOUT_EN
            end else if (cnt_q == CNT_LIMIT) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign PSEL      = (state_q != IDLE);
   assign PENABLE   = (state_q == ACCESS);
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule
